// File: rtl/signed_bcd_counter.sv
// rtl/signed_bcd_counter.sv - sign-magnitude BCD up/down counter driven by one-cycle key command pulses
// Optional wrap at +/-Max instead of saturation when COUNTER_WRAP_EN is defined.
module signed_bcd_counter #(
  parameter int Digits    = 4,
  parameter int InitValue = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iUp,
  input  logic                  iDown,
  input  logic                  iSigned,
  input  logic                  iClear,
  output logic [4*Digits-1:0]   oDigits,
  output logic                  oNegative,
  output logic                  oZero,
  output logic                  oChanged
);

  localparam int W = 4 * Digits;

  function automatic logic [W-1:0] to_bcd(input int value);
    int rem;
    to_bcd = '0;
    rem = value;
    for (int i = 0; i < Digits; i++) begin
      to_bcd[i*4 +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic carry;
    bcd_inc = v;
    carry = 1'b1;
    for (int i = 0; i < Digits; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          bcd_inc[i*4 +: 4] = 4'd0;
        end else begin
          bcd_inc[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic borrow;
    bcd_dec = v;
    borrow = 1'b1;
    for (int i = 0; i < Digits; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          bcd_dec[i*4 +: 4] = 4'd9;
        end else begin
          bcd_dec[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  endfunction

  localparam logic [W-1:0] INIT_BCD = to_bcd(InitValue);
  localparam logic [W-1:0] MAX_BCD  = {Digits{4'h9}};

  logic [W-1:0] inc_val, dec_val, next_mag;
  logic         next_neg, changed, mag_zero, mag_max;
  logic [1:0]   n_cmds;

  assign inc_val  = bcd_inc(oDigits);
  assign dec_val  = bcd_dec(oDigits);
  assign mag_zero = (oDigits == '0);
  assign mag_max  = (oDigits == MAX_BCD);
  assign n_cmds   = {1'b0, iUp} + {1'b0, iDown} + {1'b0, iSigned};

  // Conflicting Up/Down/Signed pulses in one cycle are dropped entirely.
  always_comb begin
    next_mag = oDigits;
    next_neg = oNegative;
    changed  = 1'b0;
    if (iClear) begin
      next_mag = '0;
      next_neg = 1'b0;
      changed  = !mag_zero;
    end else if (n_cmds == 2'd1) begin
      if (iUp) begin
        if (oNegative) begin
          next_mag = dec_val;
          changed  = 1'b1;
          if (dec_val == '0) next_neg = 1'b0;
        end else if (mag_max) begin
`ifdef COUNTER_WRAP_EN
          next_mag = '0;
          changed  = 1'b1;
`endif
        end else begin
          next_mag = inc_val;
          changed  = 1'b1;
        end
      end else if (iDown) begin
        if (!oNegative) begin
          // +0 steps across to -1; any other positive value just shrinks.
          next_mag = mag_zero ? inc_val : dec_val;
          next_neg = mag_zero;
          changed  = 1'b1;
        end else if (mag_max) begin
`ifdef COUNTER_WRAP_EN
          next_mag = '0;
          next_neg = 1'b0;
          changed  = 1'b1;
`endif
        end else begin
          next_mag = inc_val;
          changed  = 1'b1;
        end
      end else if (!mag_zero) begin
        next_neg = !oNegative;
        changed  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oDigits   <= INIT_BCD;
      oNegative <= 1'b0;
      oZero     <= (INIT_BCD == '0);
      oChanged  <= 1'b0;
    end else begin
      oDigits   <= next_mag;
      oNegative <= next_neg;
      oZero     <= (next_mag == '0);
      oChanged  <= changed;
    end
  end

endmodule
